// File: rtl/sub_bytes_mc.sv
// Multi-cycle AES SubBytes: LANES S-boxes per direction, 16/LANES RUN cycles per state.
// Optional feature macro SUB_BYTES_INV_EN builds the inverse S-boxes; otherwise in_inverse is ignored.
module sub_bytes_mc #(
  parameter int unsigned LANES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int unsigned NumGrp = 16 / LANES;
  localparam int unsigned GrpW = (NumGrp > 1) ? $clog2(NumGrp) : 1;
  localparam logic [GrpW-1:0] LastGrp = GrpW'(NumGrp - 1);

  // Entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] FwdTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return FwdTbl[2047 - 8*int'(b) -: 8];
  endfunction

`ifdef SUB_BYTES_INV_EN
  localparam logic [2047:0] InvTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvTbl[2047 - 8*int'(b) -: 8];
  endfunction
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state;
  logic [127:0]    st;
  logic [127:0]    st_sub;
  logic [GrpW-1:0] grp;
  logic            mode_inv;
  logic            mode_byp;

`ifndef SUB_BYTES_INV_EN
  logic unused_inverse;
  assign mode_inv       = 1'b0;
  assign unused_inverse = in_inverse ^ mode_inv;
`endif

  // Bytes grp*LANES .. grp*LANES+LANES-1 go through the S-boxes; the rest pass unchanged.
  always_comb begin
    int k;
    logic [7:0] lane_in;
    logic [7:0] lane_out;
    st_sub   = st;
    k        = 0;
    lane_in  = '0;
    lane_out = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      k       = ((NumGrp > 1) ? int'(grp) : 0) * int'(LANES) + l;
      lane_in = st[127 - 8*k -: 8];
`ifdef SUB_BYTES_INV_EN
      lane_out = mode_inv ? inv_sbox(lane_in) : sbox(lane_in);
`else
      lane_out = sbox(lane_in);
`endif
      st_sub[127 - 8*k -: 8] = lane_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      st        <= '0;
      grp       <= '0;
      mode_byp  <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      mode_inv  <= 1'b0;
`endif
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            st       <= in_state;
            grp      <= '0;
            mode_byp <= in_bypass;
`ifdef SUB_BYTES_INV_EN
            mode_inv <= in_inverse;
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_bypass) begin
              state     <= StDone;
              out_valid <= 1'b1;
            end else begin
              state <= StRun;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        StRun: begin
          if (!mode_byp) st <= st_sub;
          if (grp == LastGrp) begin
            grp       <= '0;
            state     <= StDone;
            out_valid <= 1'b1;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign out_state = st;

endmodule
